det_evt_ctr: RTL and testbench
==============================

# det_evt_ctr

Event accumulator directly downstream of the serial pattern detector `det`. Consumes its one-cycle `det_o` match pulse, keeps a saturating running match count, optionally measures the spacing between consecutive matches, and raises a level interrupt every `THRESH` matches. The interrupt is held until software or a controller acknowledges it.

## Interface
- `CNT_W`, 8: width of total match counter.
- `THRESH`, 3: matches per interrupt window. Legal range is 1 to 2^CNT_W-1.
- `GAP_W`, 8: width of inter-match gap timer. Used only with `DET_EVT_GAP_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `det_i` in 1: match pulse from `det`. Each cycle high counts as one match.
- `clr_i` in 1: synchronous clear of counters, flags and FSM.
- `ack_i` in 1: interrupt acknowledge. Single-cycle or level.
- `evt_cnt_o` out CNT_W: total matches since reset or clear. Saturating.
- `ovf_o` out 1: sticky. Set when a match arrives while `evt_cnt_o` is all-ones.
- `irq_o` out 1: window interrupt, held until acknowledged.
- `gap_o` out GAP_W: cycles between the last two matches.

## Operation
- `det_i` is sampled every rising edge. Matches on consecutive cycles (overlapping patterns) each count.
- **Total count:** `evt_cnt_o` increments by 1 per match. At all-ones it holds and sets `ovf_o`.
- **Window counter:** internal `win_cnt`, width of `THRESH`. It increments per match and saturates at `THRESH`.
- **FSM states:**
  - `ST_COUNT`: `irq_o`=0. If `win_cnt` equals `THRESH`, or `win_cnt` equals `THRESH`-1 with a match this cycle, go to `ST_IRQ` and load `win_cnt` with 0.
  - `ST_IRQ`: `irq_o`=1. Matches still count into `evt_cnt_o` and `win_cnt`. On `ack_i`, go to `ST_COUNT`. A `win_cnt` that is already full re-triggers the interrupt from `ST_COUNT` on the following edge.
- `ack_i` in `ST_COUNT` is ignored.
- `clr_i` has top priority over `det_i` and `ack_i` in the same cycle. That cycle's match is dropped. All registers return to reset values and the FSM goes to `ST_COUNT`.
- **Gap timer:**
  - The timer increments every cycle and saturates at all-ones.
  - On a match, `gap_o` loads the timer value plus 1 (saturating) and the timer restarts at 0. Matches in consecutive cycles therefore give `gap_o`=1.
  - The first match after reset or clear only arms the timer; `gap_o` stays 0.

## Timing
- Reset values: `evt_cnt_o`=0, `ovf_o`=0, `irq_o`=0, `gap_o`=0, `win_cnt`=0, state `ST_COUNT`, gap-armed flag 0.
- `rst` acts immediately (asynchronous), including in `ST_IRQ` mid-window. Release is synchronous to `clk`.
- All outputs are registered.
- Latency from `det_i` high at edge k:
  - `evt_cnt_o`, `gap_o` and `ovf_o` update after edge k.
  - `irq_o` rises after edge k for the `THRESH`-th match.
- `ack_i` at edge k drops `irq_o` after edge k. Minimum low time before a re-trigger is 1 cycle.
- Match and `ack_i` in the same cycle in `ST_IRQ`: the match is counted into the new window.

## Configuration
- `DET_EVT_GAP_EN` defined: gap timer, armed flag and `gap_o` register are compiled in as described.
- `DET_EVT_GAP_EN` not defined: no gap logic. `gap_o` is tied to 0 and the port remains for interface stability.

## Structure
- Package `det_evt_pkg` holds:
  - the FSM state enum (`ST_COUNT`, `ST_IRQ`);
  - default width constants;
  - the `THRESH` legality check constant.
- Sub-module `sat_cnt` (parameter `W`; inputs inc, clr; outputs count, at_max) is instantiated for `evt_cnt_o` and for the gap timer.
- The window counter and FSM live in the top module.

## Test plan
All scenarios use `THRESH`=3, `CNT_W`=8, `GAP_W`=8 unless stated.
- **Reset:** hold `rst` 2 cycles with `det_i` toggling -> all outputs 0. After release, still 0 with `det_i`=0.
- **Count, interrupt and gap:** matches at cycles 10, 13, 17 ->
  - `evt_cnt_o` goes 1, 2, 3;
  - `gap_o` goes 0, 3, 4;
  - `irq_o` is 1 from cycle 18.
- **Acknowledge and re-trigger:**
  - With `irq_o`=1, 3 matches then `ack_i` at cycle 30 -> `irq_o`=0 at 31 and 1 again at 32; `evt_cnt_o`=6.
  - `ack_i` while `irq_o`=0 -> no effect.
- **Saturation:** with `CNT_W`=4, 17 back-to-back matches -> `evt_cnt_o` holds 15, `ovf_o`=1 from the 16th match, `gap_o`=1.
- **Clear priority:** `clr_i` and `det_i` high in the same cycle during `ST_IRQ` ->
  - next cycle all outputs 0;
  - the following match leaves `evt_cnt_o`=1 and `gap_o`=0.
- **Async reset mid-interrupt:** assert `rst` mid-cycle while `irq_o`=1 -> `irq_o` and counters go to 0 before the next edge. Build with and without `DET_EVT_GAP_EN` and confirm `gap_o`=0 throughout when the macro is off.

Source files
------------

// File: rtl/det_evt_pkg.sv
// Shared types and constants for the det_evt_ctr event accumulator.
package det_evt_pkg;

  // Interrupt FSM states
  typedef enum logic [0:0] {
    ST_COUNT = 1'b0,
    ST_IRQ   = 1'b1
  } state_e;

  // Default widths and window size
  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_GAP_W  = 8;
  localparam int unsigned DEF_THRESH = 3;

  // Smallest window that makes sense
  localparam int unsigned THRESH_MIN = 1;

  // THRESH must fit in [THRESH_MIN, 2^cnt_w - 1]
  function automatic bit thresh_legal(input int unsigned thresh, input int unsigned cnt_w);
    return (thresh >= THRESH_MIN) &&
           (64'(thresh) <= ((64'(1) << cnt_w) - 64'(1)));
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_q, count_d;

  assign at_max = &count_q;
  assign count  = count_q;

  // Next count: clear, else increment unless already at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/det_evt_ctr.sv
// Match-event accumulator for the det pattern detector: saturating total count,
// sticky overflow, windowed level interrupt with acknowledge, optional gap timer.
// Optional feature macro: DET_EVT_GAP_EN (inter-match gap measurement on gap_o).
module det_evt_ctr
  import det_evt_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned THRESH = DEF_THRESH,
  parameter int unsigned GAP_W  = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_i,
  input  logic             clr_i,
  input  logic             ack_i,
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic             ovf_o,
  output logic             irq_o,
  output logic [GAP_W-1:0] gap_o
);

  localparam bit          THRESH_OK = thresh_legal(THRESH, CNT_W);
  localparam int unsigned WIN_W     = $clog2(THRESH + 1);
  localparam logic [WIN_W-1:0] WIN_FULL = WIN_W'(THRESH);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(THRESH - 1);

  // Reject an unusable window size at elaboration
  if (!THRESH_OK) begin : g_bad_thresh
    $error("det_evt_ctr: THRESH out of range for CNT_W");
  end

  logic             match_c;
  logic             evt_at_max;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;
  logic [WIN_W-1:0] win_q, win_d;
  state_e           state_q, state_d;

  // A match in a clear cycle is dropped
  assign match_c = det_i & ~clr_i;

  // Total match counter
  sat_cnt #(.W(CNT_W)) u_evt_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (det_i),
    .clr    (clr_i),
    .count  (evt_cnt_o),
    .at_max (evt_at_max)
  );

  // Sticky overflow and window FSM next-state
  always_comb begin
    ovf_d   = ovf_q;
    state_d = state_q;
    win_d   = win_q;
    if (clr_i) begin
      ovf_d   = 1'b0;
      state_d = ST_COUNT;
      win_d   = '0;
    end else begin
      ovf_d = ovf_q | (det_i & evt_at_max);
      case (state_q)
        ST_COUNT: begin
          if ((win_q == WIN_FULL) || ((win_q == WIN_LAST) && match_c)) begin
            state_d = ST_IRQ;
            win_d   = '0;
          end else if (match_c) begin
            win_d = win_q + WIN_W'(1);
          end
        end
        ST_IRQ: begin
          if (match_c && (win_q != WIN_FULL)) begin
            win_d = win_q + WIN_W'(1);
          end
          if (ack_i) begin
            state_d = ST_COUNT;
          end
        end
        default: state_d = ST_COUNT;
      endcase
    end
    irq_d = (state_d == ST_IRQ);
  end

  // Overflow, FSM state, window count and interrupt registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      state_q <= ST_COUNT;
      win_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      state_q <= state_d;
      win_q   <= win_d;
      irq_q   <= irq_d;
    end
  end

  assign ovf_o = ovf_q;
  assign irq_o = irq_q;

`ifdef DET_EVT_GAP_EN
  logic [GAP_W-1:0] tmr_cnt;
  logic             tmr_at_max;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             armed_q, armed_d;

  // Free-running gap timer, restarted by every match or clear
  sat_cnt #(.W(GAP_W)) u_gap_tmr (
    .clk    (clk),
    .rst    (rst),
    .inc    (1'b1),
    .clr    (clr_i | det_i),
    .count  (tmr_cnt),
    .at_max (tmr_at_max)
  );

  // Capture timer+1 on a match once armed by an earlier match
  always_comb begin
    gap_d   = gap_q;
    armed_d = armed_q;
    if (clr_i) begin
      gap_d   = '0;
      armed_d = 1'b0;
    end else if (det_i) begin
      armed_d = 1'b1;
      if (armed_q) begin
        gap_d = tmr_at_max ? {GAP_W{1'b1}} : (tmr_cnt + GAP_W'(1));
      end
    end
  end

  // Gap result and armed flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      armed_q <= armed_d;
    end
  end

  assign gap_o = gap_q;
`else
  assign gap_o = {GAP_W{1'b0}};
`endif

endmodule

// File: tb/tb_det_evt_ctr.sv
// Directed self-checking bench for det_evt_ctr (default build and DET_EVT_GAP_EN).
module tb_det_evt_ctr;

`ifdef DET_EVT_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       det = 1'b0;
  logic       clr = 1'b0;
  logic       ack = 1'b0;

  logic [7:0] evt;
  logic       ovf;
  logic       irq;
  logic [7:0] gap;
  logic [3:0] s_evt;
  logic       s_ovf;
  logic       s_irq;
  logic [7:0] s_gap;

  int tests = 0;
  int fails = 0;

  det_evt_ctr #(.CNT_W(8), .THRESH(3), .GAP_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .det_i     (det),
    .clr_i     (clr),
    .ack_i     (ack),
    .evt_cnt_o (evt),
    .ovf_o     (ovf),
    .irq_o     (irq),
    .gap_o     (gap)
  );

  det_evt_ctr #(.CNT_W(4), .THRESH(3), .GAP_W(8)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .det_i     (det),
    .clr_i     (clr),
    .ack_i     (ack),
    .evt_cnt_o (s_evt),
    .ovf_o     (s_ovf),
    .irq_o     (s_irq),
    .gap_o     (s_gap)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] g(input logic [31:0] v);
    return GAP_EN ? v : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int e, input int o, input int i, input int gp);
    chk({tag, ".evt"}, 32'(evt), 32'(e));
    chk({tag, ".ovf"}, 32'(ovf), 32'(o));
    chk({tag, ".irq"}, 32'(irq), 32'(i));
    chk({tag, ".gap"}, 32'(gap), g(32'(gp)));
  endtask

  initial begin
    // Reset held 2 cycles with det toggling
    rst = 1'b1;
    det = 1'b1; tick();
    det = 1'b0; tick();
    chk_main("rst_hold", 0, 0, 0, 0);
    chk("rst_hold.s_evt", 32'(s_evt), 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk_main("rst_rel", 0, 0, 0, 0);

    // Matches spaced 3 then 4 cycles apart
    tick(); tick();
    det = 1'b1; tick(); det = 1'b0;
    chk_main("m1", 1, 0, 0, 0);
    tick(); tick();
    det = 1'b1; tick(); det = 1'b0;
    chk_main("m2", 2, 0, 0, 3);
    tick(); tick(); tick();
    det = 1'b1; tick(); det = 1'b0;
    chk_main("m3", 3, 0, 1, 4);
    tick(); tick();
    chk_main("irq_hold", 3, 0, 1, 4);

    // Three back-to-back matches inside ST_IRQ, then ack and re-trigger
    det = 1'b1; tick(); tick(); tick(); det = 1'b0;
    chk_main("irq_m3", 6, 0, 1, 1);
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk_main("ack_drop", 6, 0, 0, 1);
    tick();
    chk_main("retrig", 6, 0, 1, 1);

    // Ack back to ST_COUNT, then ack in ST_COUNT is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack2.irq", 32'(irq), 32'd0);
    tick();
    chk("idle.irq", 32'(irq), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk_main("ack_idle", 6, 0, 0, 1);

    // Fill a fresh window, then match together with ack
    det = 1'b1; tick(); tick();
    chk("win2.irq", 32'(irq), 32'd0);
    tick();
    chk_main("win3", 9, 0, 1, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk_main("m_ack", 10, 0, 0, 1);
    tick();
    chk_main("m_ack+1", 11, 0, 0, 1);
    tick(); det = 1'b0;
    chk_main("m_ack+2", 12, 0, 1, 1);

    // Clear with a match in ST_IRQ: match dropped, everything cleared
    det = 1'b1; clr = 1'b1; tick(); clr = 1'b0; det = 1'b0;
    chk_main("clr", 0, 0, 0, 0);
    chk("clr.s_evt", 32'(s_evt), 32'd0);
    tick(); tick();
    det = 1'b1; tick(); det = 1'b0;
    chk_main("clr_m1", 1, 0, 0, 0);

    // Saturation on the 4-bit instance: 17 back-to-back matches
    clr = 1'b1; tick(); clr = 1'b0;
    det = 1'b1;
    for (int k = 1; k <= 15; k++) tick();
    chk("sat15.s_evt", 32'(s_evt), 32'd15);
    chk("sat15.s_ovf", 32'(s_ovf), 32'd0);
    tick();
    chk("sat16.s_evt", 32'(s_evt), 32'd15);
    chk("sat16.s_ovf", 32'(s_ovf), 32'd1);
    tick(); det = 1'b0;
    chk("sat17.s_evt", 32'(s_evt), 32'd15);
    chk("sat17.s_ovf", 32'(s_ovf), 32'd1);
    chk("sat17.s_gap", 32'(s_gap), g(32'd1));
    chk("sat17.s_irq", 32'(s_irq), 32'd1);
    chk_main("sat17", 17, 0, 1, 1);
    tick();
    chk("sat_sticky.s_ovf", 32'(s_ovf), 32'd1);

    // Asynchronous reset mid-cycle while the interrupt is up
    #2;
    rst = 1'b1;
    #1;
    chk_main("arst", 0, 0, 0, 0);
    chk("arst.s_ovf", 32'(s_ovf), 32'd0);
    chk("arst.s_evt", 32'(s_evt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_main("arst_rel", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
